// File: rtl/reg_read_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reg_read_sequencer
//  Description : Accepts one read request holding NUM_SLOTS register
//                selectors plus a slot mask, then streams the selected
//                register values onto the operand bus. It issues one beat per
//                enabled slot using a valid/ready handshake. It sits between
//                the decoder and the ALU operand latch.
//  Ports       : clock, reset_n       - rising-edge clock, async active-low reset
//                req_valid/req_ready  - request handshake (ready while idle)
//                req_sel, req_mask    - per-slot selectors and enable mask
//                reg_flat             - live register file values
//                out_valid/out_ready  - beat handshake
//                out_data, out_slot,
//                out_last, out_err    - beat payload
//                wr_en/wr_sel/wr_data - write-through forwarding (BYPASS_EN only)
//  Options     : define BYPASS_EN to add write-through forwarding of wr_data
//                into a beat being loaded for the same selector.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_read_sequencer #(
    parameter  int DATA_W    = 32,
    parameter  int NUM_REGS  = 8,
    parameter  int SEL_W     = 4,
    parameter  int NUM_SLOTS = 2,
    parameter  int IMM_SEL   = 3,
    localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
`ifdef BYPASS_EN
    input  logic                          wr_en,
    input  logic [SEL_W-1:0]              wr_sel,
    input  logic [DATA_W-1:0]             wr_data,
`endif
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [NUM_SLOTS*SEL_W-1:0]    req_sel,
    input  logic [NUM_SLOTS-1:0]          req_mask,
    input  logic [NUM_REGS*DATA_W-1:0]    reg_flat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic [SLOT_W-1:0]             out_slot,
    output logic                          out_last,
    output logic                          out_err
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                       r_state;
    logic [NUM_SLOTS*SEL_W-1:0]   r_sel;
    logic [NUM_SLOTS-1:0]         r_mask;
    logic                         r_valid;
    logic [DATA_W-1:0]            r_data;
    logic [SLOT_W-1:0]            r_slot;
    logic                         r_last;
    logic                         r_err;

    logic                         w_idle;
    logic                         w_accept;
    logic                         w_advance;
    logic [SLOT_W-1:0]            w_first_idx;
    logic [SLOT_W-1:0]            w_next_idx;
    logic [SLOT_W-1:0]            w_load_idx;
    logic [NUM_SLOTS-1:0]         w_load_mask;
    logic [SEL_W-1:0]             w_load_sel;
    logic                         w_load_last;
    logic [DATA_W-1:0]            w_load_data;
    logic                         w_load_err;

    assign w_idle    = (r_state == S_IDLE);
    assign req_ready = w_idle;
    assign w_accept  = req_valid && w_idle;
    assign w_advance = r_valid && out_ready;

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_slot  = r_slot;
    assign out_last  = r_last;
    assign out_err   = r_err;

    // Priority encoders: lowest set slot of a new request, and the lowest
    // set slot strictly above the current beat. Scanning downwards lets the
    // lowest match win, so cleared slots are skipped without bubbles.
    always_comb begin
        w_first_idx = '0;
        w_next_idx  = '0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (req_mask[k]) begin
                w_first_idx = SLOT_W'(k);
            end
            if (r_mask[k] && (k > int'(r_slot))) begin
                w_next_idx = SLOT_W'(k);
            end
        end
    end

    // While idle, the beat being loaded comes from the incoming request.
    // Otherwise it comes from the latched one.
    assign w_load_mask = w_idle ? req_mask : r_mask;
    assign w_load_idx  = w_idle ? w_first_idx : w_next_idx;
    assign w_load_sel  = w_idle ? req_sel[int'(w_first_idx)*SEL_W +: SEL_W]
                                : r_sel[int'(w_next_idx)*SEL_W +: SEL_W];

    always_comb begin
        w_load_last = 1'b1;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (w_load_mask[k] && (k > int'(w_load_idx))) begin
                w_load_last = 1'b0;
            end
        end
    end

    // The immediate code wins even when it aliases a real register index.
    always_comb begin
        w_load_data = '0;
        w_load_err  = 1'b0;
        if (int'(w_load_sel) == IMM_SEL) begin
            w_load_data = '0;
        end else if (int'(w_load_sel) < NUM_REGS) begin
            w_load_data = reg_flat[int'(w_load_sel)*DATA_W +: DATA_W];
`ifdef BYPASS_EN
            if (wr_en && (wr_sel == w_load_sel)) begin
                w_load_data = wr_data;
            end
`endif
        end else begin
            w_load_err = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_mask  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_slot  <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sel  <= req_sel;
                        r_mask <= req_mask;
                        // An all-clear mask is consumed without producing beats.
                        if (|req_mask) begin
                            r_valid <= 1'b1;
                            r_data  <= w_load_data;
                            r_slot  <= w_load_idx;
                            r_last  <= w_load_last;
                            r_err   <= w_load_err;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_advance) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_valid <= 1'b1;
                            r_data  <= w_load_data;
                            r_slot  <= w_load_idx;
                            r_last  <= w_load_last;
                            r_err   <= w_load_err;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
